// File: rtl/video_frame_analyzer.sv
// rtl/video_frame_analyzer.sv - per-frame geometry, lock and width-consistency monitor for a sync/dval video stream
// Optional pixel checksum is compiled in with `define VFA_CHECKSUM_EN.
module video_frame_analyzer #(
  parameter int CNT_W      = 12,
  parameter int EXP_WIDTH  = 640,
  parameter int EXP_HEIGHT = 480
) (
  input  logic             px_clk,
  input  logic             sys_rst,
  input  logic             vsync_i,
  input  logic             hsync_i,
  input  logic             dval_i,
  input  logic [7:0]       rdata_i,
  input  logic [7:0]       gdata_i,
  input  logic [7:0]       bdata_i,
  output logic [CNT_W-1:0] width_o,
  output logic [CNT_W-1:0] height_o,
  output logic [15:0]      frame_cnt_o,
  output logic [31:0]      checksum_o,
  output logic             width_err_o,
  output logic             locked_o,
  output logic             frame_done_o
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;

  logic vs_r, hs_r, dv_r;
  logic vs_p, hs_p;
  logic vs_rise, hs_rise, dv_q;

  logic [CNT_W-1:0] pix_cnt, line_cnt, ref_width;
  logic             err;
  logic             match_streak;

  logic [CNT_W-1:0] pix_eff, lines_eff, ref_eff;
  logic             err_eff, line_close, active_close, first_line, frame_match;

  // Sync history resets high so a sync already asserted at reset release is not an edge.
  always_ff @(posedge px_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vs_r    <= 1'b1;
      hs_r    <= 1'b1;
      vs_p    <= 1'b1;
      hs_p    <= 1'b1;
      dv_r    <= 1'b0;
      vs_rise <= 1'b0;
      hs_rise <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      vs_r    <= vsync_i;
      hs_r    <= hsync_i;
      dv_r    <= dval_i;
      vs_p    <= vs_r;
      hs_p    <= hs_r;
      vs_rise <= vs_r & ~vs_p;
      hs_rise <= hs_r & ~hs_p;
      dv_q    <= dv_r;
    end
  end

  // Effective per-cycle values: the current pixel is folded into a line closing on the same cycle.
  always_comb begin
    pix_eff      = (dv_q && pix_cnt != CNT_MAX) ? pix_cnt + CNT_W'(1) : pix_cnt;
    line_close   = hs_rise | vs_rise;
    active_close = line_close && (pix_eff != '0);
    first_line   = (line_cnt == '0);
    ref_eff      = (active_close && first_line) ? pix_eff : ref_width;
    err_eff      = err | (active_close && !first_line && (pix_eff != ref_width));
    lines_eff    = (active_close && line_cnt != CNT_MAX) ? line_cnt + CNT_W'(1) : line_cnt;
    frame_match  = (ref_eff == CNT_W'(EXP_WIDTH)) && (lines_eff == CNT_W'(EXP_HEIGHT)) && !err_eff;
  end

  always_ff @(posedge px_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vs_rise) state_nxt = MEASURE;
      MEASURE: state_nxt = MEASURE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge px_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pix_cnt      <= '0;
      line_cnt     <= '0;
      ref_width    <= '0;
      err          <= 1'b0;
      match_streak <= 1'b0;
      width_o      <= '0;
      height_o     <= '0;
      frame_cnt_o  <= '0;
      width_err_o  <= 1'b0;
      locked_o     <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (state == IDLE) begin
        pix_cnt   <= '0;
        line_cnt  <= '0;
        ref_width <= '0;
        err       <= 1'b0;
      end else if (vs_rise) begin
        width_o      <= ref_eff;
        height_o     <= lines_eff;
        width_err_o  <= err_eff;
        frame_cnt_o  <= frame_cnt_o + 16'd1;
        frame_done_o <= 1'b1;
        locked_o     <= frame_match && match_streak;
        match_streak <= frame_match;
        pix_cnt      <= '0;
        line_cnt     <= '0;
        ref_width    <= '0;
        err          <= 1'b0;
      end else begin
        pix_cnt   <= line_close ? '0 : pix_eff;
        line_cnt  <= lines_eff;
        ref_width <= ref_eff;
        err       <= err_eff;
      end
    end
  end

`ifdef VFA_CHECKSUM_EN
  logic [7:0]  r_r, g_r, b_r;
  logic [9:0]  px_sum_q;
  logic [31:0] sum, sum_eff;

  // RGB is summed one stage early so px_sum_q lines up with dv_q.
  always_comb begin
    sum_eff = dv_q ? sum + {22'd0, px_sum_q} : sum;
  end

  always_ff @(posedge px_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_r        <= '0;
      g_r        <= '0;
      b_r        <= '0;
      px_sum_q   <= '0;
      sum        <= '0;
      checksum_o <= '0;
    end else begin
      r_r      <= rdata_i;
      g_r      <= gdata_i;
      b_r      <= bdata_i;
      px_sum_q <= {2'b00, r_r} + {2'b00, g_r} + {2'b00, b_r};
      if (state == IDLE) begin
        sum <= '0;
      end else if (vs_rise) begin
        checksum_o <= sum_eff;
        sum        <= '0;
      end else begin
        sum <= sum_eff;
      end
    end
  end
`else
  logic unused_rgb;
  assign unused_rgb = ^{rdata_i, gdata_i, bdata_i};
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_video_frame_analyzer.sv
// tb/tb_video_frame_analyzer.sv - directed self-checking bench for video_frame_analyzer (8x4 geometry)
module tb_video_frame_analyzer;

  logic        px_clk;
  logic        sys_rst;
  logic        vsync_i, hsync_i, dval_i;
  logic [7:0]  rdata_i, gdata_i, bdata_i;
  logic [11:0] width_o, height_o;
  logic [15:0] frame_cnt_o;
  logic [31:0] checksum_o;
  logic        width_err_o, locked_o, frame_done_o;

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;

`ifdef VFA_CHECKSUM_EN
  localparam int CK_FULL  = 192;
  localparam int CK_SHORT = 186;
`else
  localparam int CK_FULL  = 0;
  localparam int CK_SHORT = 0;
`endif

  video_frame_analyzer #(
    .CNT_W(12),
    .EXP_WIDTH(8),
    .EXP_HEIGHT(4)
  ) dut (
    .px_clk(px_clk),
    .sys_rst(sys_rst),
    .vsync_i(vsync_i),
    .hsync_i(hsync_i),
    .dval_i(dval_i),
    .rdata_i(rdata_i),
    .gdata_i(gdata_i),
    .bdata_i(bdata_i),
    .width_o(width_o),
    .height_o(height_o),
    .frame_cnt_o(frame_cnt_o),
    .checksum_o(checksum_o),
    .width_err_o(width_err_o),
    .locked_o(locked_o),
    .frame_done_o(frame_done_o)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  always @(negedge px_clk) if (frame_done_o === 1'b1) done_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge px_clk);
    #1;
  endtask

  task automatic pixels(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      dval_i = 1'b1;
      tick();
      if (gaps) begin
        dval_i = 1'b0;
        tick();
      end
    end
    dval_i = 1'b0;
  endtask

  task automatic hs_pulse;
    hsync_i = 1'b1;
    tick();
    hsync_i = 1'b0;
    tick();
  endtask

  task automatic send_line(input int n, input bit gaps);
    hs_pulse();
    pixels(n, gaps);
    tick();
  endtask

  task automatic send_frame(input int w0, input int w1, input int w2, input int w3);
    send_line(w0, 1'b0);
    send_line(w1, 1'b0);
    send_line(w2, 1'b0);
    send_line(w3, 1'b0);
  endtask

  // vsync first sampled high at edge k; the report must appear after edge k+2 and not before.
  task automatic vs_pulse(input string tag, input bit expect_done, input bit with_hs);
    vsync_i = 1'b1;
    hsync_i = with_hs;
    tick();
    vsync_i = 1'b0;
    hsync_i = 1'b0;
    tick();
    chk({tag, "_done_k1"}, frame_done_o, 0);
    tick();
    chk({tag, "_done_k2"}, frame_done_o, expect_done);
    tick();
    chk({tag, "_done_k3"}, frame_done_o, 0);
  endtask

  task automatic chk_report(input string tag, input int w, input int h, input int cnt,
                            input int err, input int lk, input int ck);
    chk({tag, "_width"}, width_o, w);
    chk({tag, "_height"}, height_o, h);
    chk({tag, "_frame_cnt"}, frame_cnt_o, cnt);
    chk({tag, "_width_err"}, width_err_o, err);
    chk({tag, "_locked"}, locked_o, lk);
    chk({tag, "_checksum"}, checksum_o, ck);
  endtask

  initial begin
    sys_rst = 1'b1;
    vsync_i = 1'b0;
    hsync_i = 1'b0;
    dval_i  = 1'b0;
    rdata_i = 8'd1;
    gdata_i = 8'd2;
    bdata_i = 8'd3;
    repeat (3) tick();
    chk_report("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_done", frame_done_o, 0);
    sys_rst = 1'b0;
    tick();

    // partial frame before the first vsync is never reported
    send_line(8, 1'b0);
    send_line(8, 1'b0);
    vs_pulse("vs1", 1'b0, 1'b0);
    chk("vs1_frame_cnt", frame_cnt_o, 0);

    send_frame(8, 8, 8, 8);
    vs_pulse("vs2", 1'b1, 1'b0);
    chk_report("f1", 8, 4, 1, 0, 0, CK_FULL);

    send_frame(8, 8, 8, 8);
    vs_pulse("vs3", 1'b1, 1'b0);
    chk_report("f2", 8, 4, 2, 0, 1, CK_FULL);

    send_frame(8, 7, 8, 8);
    vs_pulse("vs4", 1'b1, 1'b0);
    chk_report("f3_short", 8, 4, 3, 1, 0, CK_SHORT);

    send_frame(8, 8, 8, 8);
    vs_pulse("vs5", 1'b1, 1'b0);
    chk_report("f4", 8, 4, 4, 0, 0, CK_FULL);

    send_frame(8, 8, 8, 8);
    vs_pulse("vs6", 1'b1, 1'b0);
    chk_report("f5_relock", 8, 4, 5, 0, 1, CK_FULL);

    // gapped line, blanking line, and last line closed by coincident hsync+vsync
    send_line(8, 1'b1);
    hs_pulse();
    send_line(8, 1'b0);
    send_line(8, 1'b0);
    hs_pulse();
    pixels(8, 1'b0);
    vs_pulse("vs7", 1'b1, 1'b1);
    chk_report("f6_mixed", 8, 4, 6, 0, 1, CK_FULL);

    // reset mid-frame while locked
    send_line(8, 1'b0);
    send_line(8, 1'b0);
    sys_rst = 1'b1;
    #1;
    chk_report("midrst", 0, 0, 0, 0, 0, 0);
    chk("midrst_done", frame_done_o, 0);
    tick();
    sys_rst = 1'b0;
    tick();
    send_line(8, 1'b0);
    vs_pulse("vs8", 1'b0, 1'b0);
    chk("vs8_frame_cnt", frame_cnt_o, 0);
    send_frame(8, 8, 8, 8);
    vs_pulse("vs9", 1'b1, 1'b0);
    chk_report("f7_post_rst", 8, 4, 1, 0, 0, CK_FULL);

    repeat (4) tick();
    chk("done_pulse_total", done_seen, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
